// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath.
//   neuron_state_t : sequencer state encoding
//   NN_*           : default operand / accumulator / output widths (MSB indices, AW is a width)
//   sat_shift      : arithmetic right shift followed by signed clipping, used for
//                    requantization here and by later layers
package nn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      OUT   = 2'd2
   } neuron_state_t;

   localparam int NN_IP = 8;
   localparam int NN_WP = 8;
   localparam int NN_AW = 24;
   localparam int NN_OP = 8;

   typedef struct packed {
      logic              sat;
      logic signed [63:0] val;
   } sat_res_t;

   // Floor-shift v right by 'shift', then clip into the signed range of an
   // (op+1)-bit result. val always lies inside that range; sat flags clipping.
   function automatic sat_res_t sat_shift(input logic signed [63:0] v,
                                          input int unsigned shift,
                                          input int unsigned op);
      sat_res_t          r;
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = v >>> shift;
      hi = (64'sd1 <<< op) - 64'sd1;
      lo = -(64'sd1 <<< op);
      if (s > hi) begin
         r.sat = 1'b1;
         r.val = hi;
      end else if (s < lo) begin
         r.sat = 1'b1;
         r.val = lo;
      end else begin
         r.sat = 1'b0;
         r.val = s;
      end
      return r;
   endfunction

endpackage

// File: rtl/mac.sv
// Combinational multiply-accumulate: out = b + in * w (signed).
// The product is formed at CP+1 bits and added to a BP+1-bit bias; the sum
// wraps modulo 2^(BP+1). Choose CP >= IP+WP+1 for an exact product.
//   in  : signed activation, IP+1 bits
//   w   : signed weight, WP+1 bits
//   b   : signed bias / running sum, BP+1 bits
//   out : signed sum, BP+1 bits
module mac #(
   parameter int IP = 8,
   parameter int WP = 8,
   parameter int CP = 23,
   parameter int BP = 23
) (
   input  logic signed [IP:0] in,
   input  logic signed [WP:0] w,
   input  logic signed [BP:0] b,
   output logic signed [BP:0] out
);

   logic signed [CP:0] in_ext;
   logic signed [CP:0] w_ext;
   logic signed [CP:0] prod;

   // Widen both operands first so the multiply itself happens at CP+1 bits.
   assign in_ext = (CP+1)'(in);
   assign w_ext  = (CP+1)'(w);
   assign prod   = in_ext * w_ext;
   assign out    = b + (BP+1)'(prod);

endmodule

// File: rtl/neuron_seq.sv
// Sequential neuron: streams N (activation, weight) pairs through one mac,
// feeding the running sum back as the bias, then applies optional ReLU,
// arithmetic-shift requantization and saturation, and offers the result
// over a valid/ready handshake.
//   clk, rst_n       : clock, async active-low reset
//   start, bias      : begin a neuron with the given initial accumulator
//   busy             : sequencer not idle
//   x_valid/x_ready  : pair handshake, pair on x_data / w_data
//   o_valid/o_ready  : result handshake, result on o_data / o_sat
//
// state | meaning
// IDLE  | waiting for start
// ACCUM | accepting pairs, acc += x*w per beat
// OUT   | result presented, held until o_ready
import nn_pkg::*;

module neuron_seq #(
   parameter int IP    = NN_IP,
   parameter int WP    = NN_WP,
   parameter int AW    = NN_AW,
   parameter int N     = 16,
   parameter int SHIFT = 8,
   parameter int OP    = NN_OP,
   parameter int RELU  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic signed [AW-1:0] bias,
   output logic                 busy,
   input  logic                 x_valid,
   output logic                 x_ready,
   input  logic signed [IP:0]   x_data,
   input  logic signed [WP:0]   w_data,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic signed [OP:0]   o_data,
   output logic                 o_sat
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   neuron_state_t        state;
   logic signed [AW-1:0] acc;
   logic signed [AW-1:0] mac_sum;
   logic signed [AW-1:0] relu_sum;
   logic [CW-1:0]        cnt;
   logic                 last_beat;
   sat_res_t             q;
   logic                 unused_q_hi;

   // Product kept at full accumulator width so extreme operands never truncate.
   mac #(
      .IP (IP),
      .WP (WP),
      .CP (AW-1),
      .BP (AW-1)
   ) u_mac (
      .in  (x_data),
      .w   (w_data),
      .b   (acc),
      .out (mac_sum)
   );

   // Requantize the sum that includes the current beat, so the final beat can
   // register the result directly.
   assign relu_sum    = ((RELU != 0) && mac_sum[AW-1]) ? '0 : mac_sum;
   assign q           = sat_shift(64'(relu_sum), SHIFT, OP);
   assign unused_q_hi = ^q.val[63:OP+1];

   assign last_beat = (cnt == CW'(N-1));
   assign busy      = (state != IDLE);
   assign x_ready   = (state == ACCUM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc     <= '0;
         cnt     <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_sat   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= bias;
                  cnt   <= '0;
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               if (x_valid) begin
                  acc <= mac_sum;
                  if (last_beat) begin
                     cnt     <= '0;
                     o_data  <= q.val[OP:0];
                     o_sat   <= q.sat;
                     o_valid <= 1'b1;
                     state   <= OUT;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            OUT: begin
               if (o_ready) begin
                  o_valid <= 1'b0;
                  // Back-to-back neurons: restart straight into ACCUM.
                  if (start) begin
                     acc   <= bias;
                     cnt   <= '0;
                     state <= ACCUM;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               o_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/neuron_seq.md
# neuron_seq

Sequential neuron engine that sits around the combinational `mac` stage. It streams N (activation, weight) pairs through one `mac` instance, feeding the running sum back as the bias operand. After the last pair it applies optional ReLU, an arithmetic right-shift requantization and saturation. It hands one activation to the next layer over a valid/ready handshake.

## Interface
- `IP`, 8: activation MSB index; activation is signed `IP+1` bits.
- `WP`, 8: weight MSB index; weight is signed `WP+1` bits.
- `AW`, 24: accumulator width; must be ≥ `IP+WP+2+$clog2(N)` for wrap-free use.
- `N`, 16: pairs per neuron; N ≥ 1.
- `SHIFT`, 8: requantization right shift, 0..AW-1.
- `OP`, 8: output MSB index; output is signed `OP+1` bits.
- `RELU`, 1: 1 clamps negative sums to 0 before the shift.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a neuron; sampled only when idle (see Operation).
- `bias` in AW: signed initial accumulator value, latched with `start`.
- `busy` out 1: state ≠ IDLE.
- `x_valid` in 1: pair valid.
- `x_ready` out 1: pair accepted when `x_valid && x_ready`.
- `x_data` in IP+1: signed activation.
- `w_data` in WP+1: signed weight.
- `o_valid` out 1: result valid.
- `o_ready` in 1: consumer accepts.
- `o_data` out OP+1: signed requantized result.
- `o_sat` out 1: result was clipped; qualified by `o_valid`.

## Operation
- FSM states: IDLE, ACCUM, OUT.
- IDLE:
  - `start=1`: acc←`bias`, cnt←0, go to ACCUM.
  - `x_ready=0`, `o_valid=0`.
- ACCUM:
  - `x_ready=1`.
  - Each accepted beat: acc←`mac.out` = acc + x·w, signed, wraps modulo 2^AW; cnt←cnt+1.
  - Beat with cnt==N-1: `o_data`/`o_sat` are registered from the requantized `mac.out`, and the FSM goes to OUT.
- OUT:
  - `o_valid=1`, `x_ready=0`.
  - `o_data` and `o_sat` are held stable until `o_ready`.
  - On handshake: go to IDLE, unless `start=1` in the same cycle. In that case reload acc/cnt from `bias` and go directly to ACCUM.
- `start` in ACCUM, or in OUT without handshake: ignored.
- Requantization:
  - v = (RELU && sum<0) ? 0 : sum.
  - s = v >>> SHIFT (arithmetic, floor toward −∞).
  - Clip s to [−2^OP, 2^OP−1].
  - `o_sat=1` iff clipping occurred.
- Full product is never truncated: `mac` is instantiated with CP=BP=AW−1, so −256·−256 = 65536 is exact.
- N=1: the single beat both accumulates and completes.

## Timing
- Reset values:
  - state=IDLE; acc=0; cnt=0.
  - `busy=0`, `x_ready=0`.
  - `o_valid=0`, `o_data=0`, `o_sat=0`.
- Reset asserted mid-ACCUM or mid-OUT aborts the neuron. No result is emitted and partial sums are discarded.
- `start` sampled at edge T → `x_ready=1` from T+1.
- With `x_valid` held high, the last beat is accepted at edge T+N and `o_valid` rises at T+N+1. This is the minimum latency of N+1 cycles.
- Throughput with back-to-back `start` on the handshake cycle is one neuron per N+1 cycles.
- `x_valid` gaps stall the accumulation without loss. `o_ready` low stalls indefinitely.
- Outputs are registered; `x_ready` and `busy` decode from state only, with no combinational in-to-out paths.

## Structure
- Shared package `nn_pkg` holds:
  - the state enum `neuron_state_t` (IDLE, ACCUM, OUT);
  - default width constants (`NN_IP`, `NN_WP`, `NN_AW`, `NN_OP`);
  - a `sat_shift` function for requantization, reused by later layers.
- Sub-module: one instance of the existing `mac`, with `in`=`x_data`, `w`=`w_data`, `b`=acc.
- Counter width is max(1, $clog2(N)).

## Test plan
- **Basic sum, back-to-back:** N=4, SHIFT=0, bias=10, x=1,2,3,4, w=1 each, `x_valid` always high → `o_data=20`, `o_sat=0`, `o_valid` at T+5.
- **Positive saturation:** N=16, SHIFT=8, bias=0, x=255, w=255 each → sum 1040400, shifted 4064 → `o_data=255`, `o_sat=1`.
- **ReLU and floor:**
  - RELU=1, N=1, bias=−1000, x=1, w=1 → `o_data=0`, `o_sat=0`.
  - RELU=0, SHIFT=8, sum −1 → `o_data=−1`.
- **Extreme product:** N=1, SHIFT=8, RELU=0, bias=0, x=−256, w=−256 → sum 65536 with no wrap, `o_data=255`, `o_sat=1` (256 clipped).
- **Backpressure and start handling:**
  - `o_ready=0` for 10 cycles → `o_data` stable, `x_ready=0`, `start` pulses ignored.
  - `start` on the handshake cycle → ACCUM next cycle, new bias loaded.
- **Reset mid-operation:** `rst_n` low after 2 of 4 beats → all outputs at reset values immediately. A following clean neuron produces the correct result with no leftover state.
